// File: rtl/datamem_ctrl.sv
// Parametrised single-port data memory: valid/ready requests, byte strobes,
// one-cycle read response, range checking. Optional clear sequencer: DATAMEM_CLEAR_EN.

module datamem_lane #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module datamem_ctrl #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  wr_err,
  output logic                  busy
);
  localparam int NB = DATA_W / 8;

  logic              acc, in_rng;
  logic [NB-1:0]     lane_we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdat, rd_word;

  assign acc    = req_valid && req_ready;
  assign in_rng = 32'(req_addr) < DEPTH;

`ifdef DATAMEM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_READY} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_CLEAR;
      clr_ptr   <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST) begin
            state     <= S_READY;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign req_ready = 1'b1;
  assign busy      = 1'b0;
`endif

  // One shared write port: the clear sequencer owns it while clearing,
  // otherwise it carries in-range request writes. Nothing commits in reset.
  always_comb begin
    lane_we = (acc && req_we && in_rng) ? req_be : '0;
    waddr   = req_addr;
    wdat    = req_wdata;
`ifdef DATAMEM_CLEAR_EN
    if (state == S_CLEAR) begin
      lane_we = '1;
      waddr   = clr_ptr;
      wdat    = '0;
    end
`endif
    if (!reset_n) lane_we = '0;
  end

  datamem_lane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane [NB-1:0] (
    .clk   (clk),
    .we    (lane_we),
    .waddr (waddr),
    .wdata (wdat),
    .raddr (req_addr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wr_err    <= 1'b0;
    end else begin
      rsp_valid <= acc && !req_we;
      rsp_err   <= acc && !req_we && !in_rng;
      wr_err    <= acc && req_we && !in_rng;
      if (acc && !req_we) rsp_rdata <= in_rng ? rd_word : '0;
    end
  end
endmodule

// File: tb/tb_datamem_ctrl.sv
// Bench for datamem_ctrl (DEPTH=20): vector table, hand sequences for clear and
// mid-operation reset, and random traffic against a word-array reference model.

module tb_datamem_ctrl;
  localparam int DW = 128, DEPTH = 20, AW = 5, NB = DW / 8;
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] FF00 = {{(DW-8){1'b1}}, 8'h00};

  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NB-1:0] req_be = '0;
  logic req_ready, rsp_valid, rsp_err, wr_err, busy;
  logic [DW-1:0] rsp_rdata;

  datamem_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wr_err(wr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // reference: array of words plus the expected output registers
  logic [DW-1:0] m [DEPTH];
  logic e_val = 0, e_err = 0, e_wr = 0;
  logic [DW-1:0] e_rd = '0;

  typedef struct {
    bit v; bit we; int a; logic [DW-1:0] d; logic [NB-1:0] be;
    bit ev; bit eerr; bit ewr; logic [DW-1:0] erd;
  } vec_t;
  vec_t tab [17];

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(bit v, bit we, int a, logic [DW-1:0] d, logic [NB-1:0] be);
    req_valid = v; req_we = we; req_addr = AW'(a); req_wdata = d; req_be = be;
  endtask

  task automatic model(bit v, bit we, int a, logic [DW-1:0] d, logic [NB-1:0] be);
    e_val = 0; e_err = 0; e_wr = 0;
    if (v && we) begin
      if (a < DEPTH) begin
        for (int i = 0; i < NB; i++)
          if (be[i]) m[a][8*i +: 8] = d[8*i +: 8];
      end else e_wr = 1;
    end else if (v) begin
      e_val = 1;
      if (a < DEPTH) e_rd = m[a];
      else begin e_rd = '0; e_err = 1; end
    end
  endtask

  task automatic check_outs(string nm);
    chk({nm, " rsp_valid"}, DW'(rsp_valid), DW'(e_val));
    chk({nm, " rsp_err"},   DW'(rsp_err),   DW'(e_err));
    chk({nm, " wr_err"},    DW'(wr_err),    DW'(e_wr));
    chk({nm, " rsp_rdata"}, rsp_rdata, e_rd);
  endtask

  task automatic op(string nm, bit v, bit we, int a, logic [DW-1:0] d, logic [NB-1:0] be);
    drive(v, we, a, d, be);
    model(v, we, a, d, be);
    cyc();
    check_outs(nm);
  endtask

  // called in the cycle right after reset_n rises
  task automatic after_reset(string nm);
    int n;
    n = 0;
`ifdef DATAMEM_CLEAR_EN
    chk({nm, " busy at start"}, DW'(busy), DW'(1));
    while (!req_ready && n < 200) begin
      n++;
      cyc();
    end
    chk({nm, " clear cycles"}, DW'(n), DW'(DEPTH));
    chk({nm, " busy after clear"}, DW'(busy), DW'(0));
    for (int a = 0; a < DEPTH; a++) m[a] = '0;
    for (int a = 0; a < DEPTH; a++) op({nm, " zero read"}, 1, 0, a, ONES, '1);
`else
    chk({nm, " ready first cycle"}, DW'(req_ready), DW'(1));
    for (int i = 0; i < 4; i++) begin
      chk({nm, " busy"}, DW'(busy), DW'(0));
      cyc();
    end
`endif
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [NB-1:0] rb;

    tab[0]  = '{1, 1, 3,  ONES,        '1,      0, 0, 0, '0};
    tab[1]  = '{1, 1, 3,  '0,          16'h0001, 0, 0, 0, '0};
    tab[2]  = '{1, 0, 3,  '0,          '0,      1, 0, 0, FF00};
    tab[3]  = '{1, 1, 6,  128'hABCD,   '1,      0, 0, 0, FF00};
    tab[4]  = '{1, 1, 5,  128'h1234,   '1,      0, 0, 0, FF00};
    tab[5]  = '{1, 0, 5,  '0,          '0,      1, 0, 0, 128'h1234};
    tab[6]  = '{1, 0, 6,  '0,          '0,      1, 0, 0, 128'hABCD};
    tab[7]  = '{1, 1, 19, 128'h55,     '1,      0, 0, 0, 128'hABCD};
    tab[8]  = '{1, 1, 25, ONES,        '1,      0, 0, 1, 128'hABCD};
    tab[9]  = '{1, 0, 25, '0,          '0,      1, 1, 0, '0};
    tab[10] = '{1, 0, 19, '0,          '0,      1, 0, 0, 128'h55};
    tab[11] = '{0, 1, 3,  '0,          '1,      0, 0, 0, 128'h55};
    tab[12] = '{1, 0, 3,  128'hDEAD,   '1,      1, 0, 0, FF00};
    tab[13] = '{1, 1, 3,  128'hBEEF,   '0,      0, 0, 0, FF00};
    tab[14] = '{1, 0, 3,  '0,          '0,      1, 0, 0, FF00};
    tab[15] = '{1, 1, 31, ONES,        '1,      0, 0, 1, FF00};
    tab[16] = '{1, 0, 20, '0,          '0,      1, 1, 0, '0};

    // reset state
    cyc(); cyc();
    chk("reset rsp_valid", DW'(rsp_valid), DW'(0));
    chk("reset rsp_err",   DW'(rsp_err),   DW'(0));
    chk("reset wr_err",    DW'(wr_err),    DW'(0));
    chk("reset rsp_rdata", rsp_rdata,      '0);
`ifdef DATAMEM_CLEAR_EN
    chk("reset busy",      DW'(busy),      DW'(1));
    chk("reset req_ready", DW'(req_ready), DW'(0));
`else
    chk("reset busy",      DW'(busy),      DW'(0));
    chk("reset req_ready", DW'(req_ready), DW'(1));
`endif
    reset_n = 1'b1;
    after_reset("init");
    drive(0, 0, 0, '0, '0);
    cyc();
    e_val = 0; e_err = 0; e_wr = 0;
    e_rd = rsp_rdata;  // held value from the clear reads (zero) or reset (zero)
    chk("rdata before table", rsp_rdata, '0);

    for (int i = 0; i < 17; i++) begin
      drive(tab[i].v, tab[i].we, tab[i].a, tab[i].d, tab[i].be);
      model(tab[i].v, tab[i].we, tab[i].a, tab[i].d, tab[i].be);
      cyc();
      chk($sformatf("tab[%0d] rsp_valid", i), DW'(rsp_valid), DW'(tab[i].ev));
      chk($sformatf("tab[%0d] rsp_err", i),   DW'(rsp_err),   DW'(tab[i].eerr));
      chk($sformatf("tab[%0d] wr_err", i),    DW'(wr_err),    DW'(tab[i].ewr));
      chk($sformatf("tab[%0d] rsp_rdata", i), rsp_rdata,      tab[i].erd);
    end

    // fill every word so the model is fully known, then random traffic
    for (int a = 0; a < DEPTH; a++)
      op("fill", 1, 1, a, {$urandom, $urandom, $urandom, $urandom}, '1);
    for (int n = 0; n < 400; n++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      rb = NB'($urandom);
      op($sformatf("rand%0d", n), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
         int'($urandom_range(0, 31)), rd, rb);
    end

    // write, then read, then reset on the edge after the read is accepted
    op("pre-reset write", 1, 1, 7, 128'hC0FFEE, '1);
    op("pre-reset read",  1, 0, 2, '0, '0);
    drive(0, 0, 0, '0, '0);
    reset_n = 1'b0;
    cyc();
    chk("mid-reset rsp_valid", DW'(rsp_valid), DW'(0));
    chk("mid-reset rsp_rdata", rsp_rdata, '0);
`ifdef DATAMEM_CLEAR_EN
    chk("mid-reset busy", DW'(busy), DW'(1));
`else
    chk("mid-reset busy", DW'(busy), DW'(0));
`endif
    e_val = 0; e_err = 0; e_wr = 0; e_rd = '0;
    reset_n = 1'b1;
    after_reset("rst2");
    op("post-reset read 2", 1, 0, 2, '0, '0);
    op("post-reset read 7", 1, 0, 7, '0, '0);
    op("post-reset idle",   0, 0, 0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/datamem_ctrl.md
# datamem_ctrl

Parametrised single-port data memory with a valid/ready request interface, per-byte write strobes, a registered one-cycle read response and out-of-range address checking. It replaces the fixed 32 x 128 data memory in the datapath's memory stage. It also provides an optional post-reset clear sequencer so software sees zeroed memory.

## Interface
- `DATA_W`, default 128: word width in bits; must be a multiple of 8.
- `DEPTH`, default 32: number of words; any value from 2 to 2**`ADDR_W`.
- `ADDR_W`, default 5: address width; `DEPTH` <= 2**`ADDR_W`.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request this cycle.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_addr`  in  `ADDR_W`: word address.
- `req_wdata`  in  `DATA_W`: write data.
- `req_be`  in  `DATA_W/8`: byte enables; bit i covers `wdata[8i+7:8i]`.
- `rsp_valid`  out  1: read response valid (one-cycle pulse).
- `rsp_rdata`  out  `DATA_W`: read data; holds its value until the next response.
- `rsp_err`  out  1: qualifies `rsp_valid`; set when the address was out of range.
- `wr_err`  out  1: one-cycle pulse; a write was rejected because its address was out of range.
- `busy`  out  1: high while the clear sequence runs.

## Operation
- A request is accepted on a rising edge with `req_valid && req_ready`. At most one request is accepted per cycle. There is no response backpressure.
- FSM states:
  - CLEAR: `req_ready`=0, `busy`=1. Each cycle writes all-zero to `RAM[clr_ptr]` and increments `clr_ptr`. Moves to READY on the edge that clears `DEPTH-1`.
  - READY: `req_ready`=1, `busy`=0. Stays in READY until reset.
- Accepted write with `req_addr < DEPTH`:
  - Updates only the bytes whose `req_be` bit is set.
  - `req_be` = 0 is a legal no-op.
  - No response is generated.
- Accepted write with `req_addr >= DEPTH`: memory is unchanged and `wr_err` pulses for one cycle.
- Accepted read with `req_addr < DEPTH`: on the next edge, `rsp_valid`=1, `rsp_rdata`=`RAM[addr]`, `rsp_err`=0.
- Accepted read with `req_addr >= DEPTH`: on the next edge, `rsp_valid`=1, `rsp_rdata`=0, `rsp_err`=1.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data, because the write commits on its accept edge.
- Signals with no effect:
  - `req_wdata` and `req_be` are ignored on reads.
  - Request inputs are ignored while `req_ready`=0.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_err`=0, `wr_err`=0, `rsp_rdata`=0.
  - With `DATAMEM_CLEAR_EN`: state=CLEAR, `clr_ptr`=0, `busy`=1, `req_ready`=0.
  - Without it: state=READY, `busy`=0, `req_ready`=1.
  - Memory contents are not reset, apart from the clear sequence.
- Clear duration: after `reset_n` rises, `DEPTH` edges perform the clears. `req_ready` goes high in the cycle after the final clear edge, i.e. after exactly `DEPTH` cycles.
- Read latency: exactly 1 cycle from the accept edge to `rsp_valid`. Back-to-back reads give back-to-back `rsp_valid` pulses in order.
- `rsp_valid`, `rsp_err` and `wr_err` are single-cycle pulses. `rsp_rdata` is stable until the next response.
- Reset asserted mid-operation:
  - A pending response is dropped; `rsp_valid` is 0 on the reset edge.
  - The clear sequence restarts from address 0.
  - An in-flight write that was accepted before the reset edge has already committed.

## Configuration
- `DATAMEM_CLEAR_EN` defined:
  - The CLEAR state and `clr_ptr` exist.
  - Memory reads zero at every address after each reset.
  - `busy` behaves as described above.
- `DATAMEM_CLEAR_EN` undefined:
  - Reset goes directly to READY; `req_ready`=1 from the first cycle after reset.
  - `busy` is tied to 0.
  - Memory contents after reset are unchanged from before the reset (undefined at power-up).

## Test plan
- Clear (macro on, `DEPTH`=32): deassert reset.
  - Expected: `req_ready`=0 for 32 cycles, then 1.
  - Then read all 32 addresses: every `rsp_rdata`=0 and `rsp_err`=0.
- Byte strobes: write `0xFF..FF` to addr 3 with `be`=all ones, then write `0x00..00` with `be`=`0x0001`, then read addr 3.
  - Expected: `rsp_rdata`=`0xFF..FF00` one cycle after the read is accepted.
- Back-to-back: write A=`0x1234` to addr 5, then read addr 5 on the very next cycle, then read addr 6.
  - Expected: consecutive `rsp_valid` pulses carrying `0x1234`, then the contents of addr 6.
- Out of range (`DEPTH`=20, `ADDR_W`=5):
  - Write to addr 25: `wr_err` pulses and a read of addr 25 gives `rsp_err`=1, `rsp_rdata`=0.
  - Addr 19 is unaffected.
- Reset mid-read: accept a read of addr 2 and assert `reset_n`=0 on the next edge.
  - Expected: `rsp_valid` stays 0, `busy`=1, and clearing restarts from addr 0.
- Macro off: deassert reset.
  - Expected: `req_ready`=1 on the first cycle and `busy`=0 throughout.
